// File: rtl/tabuleiro_pecas.sv
// tabuleiro_pecas: board store and conflict checker for the placement phase.
//
// Takes a candidate piece (player, type, origin, direction, orientation),
// walks its cells one per clock, flags a conflict if any cell leaves the
// 8x8 board or hits an occupied cell, and on commit writes the cells into
// the selected player's board while counting occupied cells per player.
//
// Optional build macro: HIDROAVIAO_L_EN -- tipo 2 becomes an L shape whose
// third cell is cell 1 shifted +1 along the other axis.
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  asynchronous clear, active-low
//   limpa                  synchronous clear of boards, counters and FSM
//   verifica               start a check (OCIOSO or AGUARDA)
//   armazena               commit the last checked piece (AGUARDA)
//   jogador, tipo, X1, Y1, direcao, orientacao   candidate piece
//   rd_jogador, rd_x, rd_y read-port address
//   rd_ocupado             combinational occupancy of the addressed cell
//   conflito               result of the last check (valid while pronto)
//   pronto                 high while waiting for commit/restart
//   ocupado                high while checking or writing
//   celulas_j0, celulas_j1 occupied-cell count per player (0..64)
module tabuleiro_pecas #(
  parameter int TAM = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       limpa,
  input  logic       verifica,
  input  logic       armazena,
  input  logic       jogador,
  input  logic [2:0] tipo,
  input  logic [2:0] X1,
  input  logic [2:0] Y1,
  input  logic       direcao,
  input  logic       orientacao,
  input  logic       rd_jogador,
  input  logic [2:0] rd_x,
  input  logic [2:0] rd_y,
  output logic       rd_ocupado,
  output logic       conflito,
  output logic       pronto,
  output logic       ocupado,
  output logic [6:0] celulas_j0,
  output logic [6:0] celulas_j1
);

  localparam int NCEL = 2 * TAM * TAM;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    VERIFICA = 2'd1,
    AGUARDA  = 2'd2,
    GRAVA    = 2'd3
  } estado_t;

  estado_t         estado;
  logic [NCEL-1:0] tabuleiro;

  // Latched piece
  logic       jog_l;
  logic [2:0] tipo_l;
  logic [2:0] x_l;
  logic [2:0] y_l;
  logic       dir_l;
  logic       ori_l;
  logic [2:0] k;

  // Cell count of a piece type; 0 marks an invalid type.
  function automatic logic [2:0] comprimento(input logic [2:0] t);
    case (t)
      3'd0:    comprimento = 3'd5;
      3'd1:    comprimento = 3'd4;
      3'd2:    comprimento = 3'd3;
      3'd3:    comprimento = 3'd2;
      3'd4:    comprimento = 3'd1;
      default: comprimento = 3'd0;
    endcase
  endfunction

  logic [2:0]        len;
  logic              ultima;
  logic signed [3:0] ks;
  logic signed [3:0] off;
  logic signed [3:0] cx;
  logic signed [3:0] cy;
  logic              fora;
  logic [6:0]        idx;
  logic              ocup_cel;

  assign len    = comprimento(tipo_l);
  assign ultima = (k == 3'(len - 3'd1));

  // Coordinates of cell k. Results live in 4-bit signed space: anything
  // below 0 or above 7 (x+4 peaks at 11) has bit 3 set, so bit 3 alone
  // flags an off-board cell with no wrap-around.
  always_comb begin
    ks  = signed'({1'b0, k});
    off = ori_l ? -ks : ks;
    cx  = signed'({1'b0, x_l});
    cy  = signed'({1'b0, y_l});
    if (!dir_l)
      cx = cx + off;
    else
      cy = cy + off;
`ifdef HIDROAVIAO_L_EN
    // L-shaped hidroaviao: third cell sits beside cell 1 on the other
    // axis, always in the increasing direction.
    if (tipo_l == 3'd2 && k == 3'd2) begin
      if (!dir_l) begin
        cx = signed'({1'b0, x_l}) + (ori_l ? -4'sd1 : 4'sd1);
        cy = signed'({1'b0, y_l}) + 4'sd1;
      end else begin
        cy = signed'({1'b0, y_l}) + (ori_l ? -4'sd1 : 4'sd1);
        cx = signed'({1'b0, x_l}) + 4'sd1;
      end
    end
`endif
    fora     = cx[3] | cy[3];
    idx      = {jog_l, cy[2:0], cx[2:0]};
    ocup_cel = tabuleiro[idx];
  end

  assign rd_ocupado = tabuleiro[{rd_jogador, rd_y, rd_x}];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      tabuleiro  <= '0;
      celulas_j0 <= '0;
      celulas_j1 <= '0;
      conflito   <= 1'b0;
      pronto     <= 1'b0;
      ocupado    <= 1'b0;
      jog_l      <= 1'b0;
      tipo_l     <= '0;
      x_l        <= '0;
      y_l        <= '0;
      dir_l      <= 1'b0;
      ori_l      <= 1'b0;
      k          <= '0;
    end else if (limpa) begin
      estado     <= OCIOSO;
      tabuleiro  <= '0;
      celulas_j0 <= '0;
      celulas_j1 <= '0;
      conflito   <= 1'b0;
      pronto     <= 1'b0;
      ocupado    <= 1'b0;
      k          <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (verifica) begin
            jog_l   <= jogador;
            tipo_l  <= tipo;
            x_l     <= X1;
            y_l     <= Y1;
            dir_l   <= direcao;
            ori_l   <= orientacao;
            k       <= '0;
            ocupado <= 1'b1;
            estado  <= VERIFICA;
          end
        end

        VERIFICA: begin
          if (len == 3'd0 || fora || ocup_cel) begin
            conflito <= 1'b1;
            pronto   <= 1'b1;
            ocupado  <= 1'b0;
            estado   <= AGUARDA;
          end else if (ultima) begin
            conflito <= 1'b0;
            pronto   <= 1'b1;
            ocupado  <= 1'b0;
            estado   <= AGUARDA;
          end else begin
            k <= k + 3'd1;
          end
        end

        AGUARDA: begin
          if (armazena) begin
            pronto <= 1'b0;
            k      <= '0;
            if (!conflito) begin
              ocupado <= 1'b1;
              estado  <= GRAVA;
            end else begin
              estado <= OCIOSO;
            end
          end else if (verifica) begin
            jog_l   <= jogador;
            tipo_l  <= tipo;
            x_l     <= X1;
            y_l     <= Y1;
            dir_l   <= direcao;
            ori_l   <= orientacao;
            k       <= '0;
            pronto  <= 1'b0;
            ocupado <= 1'b1;
            estado  <= VERIFICA;
          end
        end

        GRAVA: begin
          tabuleiro[idx] <= 1'b1;
          if (jog_l)
            celulas_j1 <= celulas_j1 + 7'd1;
          else
            celulas_j0 <= celulas_j0 + 7'd1;
          if (ultima) begin
            ocupado <= 1'b0;
            estado  <= OCIOSO;
          end else begin
            k <= k + 3'd1;
          end
        end

        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_tabuleiro_pecas.sv
module tb_tabuleiro_pecas;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       limpa = 1'b0;
  logic       verifica = 1'b0;
  logic       armazena = 1'b0;
  logic       jogador = 1'b0;
  logic [2:0] tipo = '0;
  logic [2:0] X1 = '0;
  logic [2:0] Y1 = '0;
  logic       direcao = 1'b0;
  logic       orientacao = 1'b0;
  logic       rd_jogador = 1'b0;
  logic [2:0] rd_x = '0;
  logic [2:0] rd_y = '0;
  logic       rd_ocupado;
  logic       conflito;
  logic       pronto;
  logic       ocupado;
  logic [6:0] celulas_j0;
  logic [6:0] celulas_j1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tabuleiro_pecas #(.TAM(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .limpa      (limpa),
    .verifica   (verifica),
    .armazena   (armazena),
    .jogador    (jogador),
    .tipo       (tipo),
    .X1         (X1),
    .Y1         (Y1),
    .direcao    (direcao),
    .orientacao (orientacao),
    .rd_jogador (rd_jogador),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_ocupado (rd_ocupado),
    .conflito   (conflito),
    .pronto     (pronto),
    .ocupado    (ocupado),
    .celulas_j0 (celulas_j0),
    .celulas_j1 (celulas_j1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic j, input int x, input int y, input logic exp);
    rd_jogador = j;
    rd_x = 3'(x);
    rd_y = 3'(y);
    #1;
    chk(tag, {31'b0, rd_ocupado}, {31'b0, exp});
  endtask

  // Present a piece and pulse verifica for one edge (E0).
  task automatic start(input string tag, input logic j, input int t, input int x, input int y,
                       input logic d, input logic o);
    jogador = j;
    tipo = 3'(t);
    X1 = 3'(x);
    Y1 = 3'(y);
    direcao = d;
    orientacao = o;
    verifica = 1'b1;
    tick();
    verifica = 1'b0;
    chk({tag, "_busy"}, {31'b0, ocupado}, 32'd1);
  endtask

  // Count edges after E0 until pronto rises (bounded), then check result.
  task automatic espera(input string tag, input int lat, input logic conf);
    int n;
    n = 0;
    while (!pronto && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_conf"}, {31'b0, conflito}, {31'b0, conf});
    chk({tag, "_idle"}, {31'b0, ocupado}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_conf", {31'b0, conflito}, 32'd0);
    chk("rst_pronto", {31'b0, pronto}, 32'd0);
    chk("rst_ocup", {31'b0, ocupado}, 32'd0);
    chk("rst_c0", {25'b0, celulas_j0}, 32'd0);
    chk("rst_c1", {25'b0, celulas_j1}, 32'd0);
    rd("rst_rd", 1'b0, 0, 0, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // 1: porta-avioes j0 at (2,2) along +X, then commit
    start("s1", 1'b0, 0, 2, 2, 1'b0, 1'b0);
    espera("s1", 5, 1'b0);
    armazena = 1'b1;
    tick();
    armazena = 1'b0;
    chk("s1_g0_pronto", {31'b0, pronto}, 32'd0);
    chk("s1_g0_ocup", {31'b0, ocupado}, 32'd1);
    tick(); tick(); tick();
    chk("s1_g3_c0", {25'b0, celulas_j0}, 32'd3);
    chk("s1_g3_ocup", {31'b0, ocupado}, 32'd1);
    tick(); tick();
    chk("s1_g5_c0", {25'b0, celulas_j0}, 32'd5);
    chk("s1_g5_ocup", {31'b0, ocupado}, 32'd0);
    for (int x = 2; x <= 7; x++)
      rd($sformatf("s1_rd_x%0d", x), 1'b0, x, 2, (x <= 6));
    rd("s1_rd_y3", 1'b0, 2, 3, 1'b0);
    rd("s1_rd_j1", 1'b1, 2, 2, 1'b0);

    // 2: encouracado j0 at (4,0) along +Y hits (4,2); commit is refused
    start("s2", 1'b0, 1, 4, 0, 1'b1, 1'b0);
    espera("s2", 3, 1'b1);
    armazena = 1'b1;
    tick();
    armazena = 1'b0;
    chk("s2_pronto", {31'b0, pronto}, 32'd0);
    chk("s2_ocup", {31'b0, ocupado}, 32'd0);
    tick(); tick();
    chk("s2_c0", {25'b0, celulas_j0}, 32'd5);
    rd("s2_rd", 1'b0, 4, 0, 1'b0);

    // 3: off the board at x=8, then restart from AGUARDA with x going to -1
    start("s3a", 1'b0, 0, 5, 0, 1'b0, 1'b0);
    espera("s3a", 4, 1'b1);
    start("s3b", 1'b0, 0, 1, 0, 1'b0, 1'b1);
    espera("s3b", 3, 1'b1);
    // armazena beats verifica; conflict so back to OCIOSO
    armazena = 1'b1;
    verifica = 1'b1;
    tick();
    armazena = 1'b0;
    verifica = 1'b0;
    chk("s3_prio_ocup", {31'b0, ocupado}, 32'd0);
    chk("s3_prio_pronto", {31'b0, pronto}, 32'd0);

    // 4: same piece on j1; inputs change after E0 and must be ignored
    start("s4", 1'b1, 0, 2, 2, 1'b0, 1'b0);
    jogador = 1'b0;
    X1 = 3'd0;
    espera("s4", 5, 1'b0);
    armazena = 1'b1;
    tick();
    armazena = 1'b0;
    repeat (5) tick();
    chk("s4_c1", {25'b0, celulas_j1}, 32'd5);
    chk("s4_c0", {25'b0, celulas_j0}, 32'd5);
    rd("s4_rd_j1", 1'b1, 6, 2, 1'b1);
    rd("s4_rd_j1_7", 1'b1, 7, 2, 1'b0);

    // 5: invalid tipo, then restart with a submarino at (0,7)
    start("s5a", 1'b0, 6, 0, 0, 1'b0, 1'b0);
    espera("s5a", 1, 1'b1);
    start("s5b", 1'b0, 4, 0, 7, 1'b0, 1'b0);
    espera("s5b", 1, 1'b0);
    armazena = 1'b1;
    tick();
    armazena = 1'b0;
    tick();
    chk("s5_c0", {25'b0, celulas_j0}, 32'd6);
    chk("s5_ocup", {31'b0, ocupado}, 32'd0);
    rd("s5_rd", 1'b0, 0, 7, 1'b1);

    // 6: reset during the 3rd GRAVA cycle
    start("s6", 1'b1, 0, 0, 5, 1'b0, 1'b0);
    espera("s6", 5, 1'b0);
    armazena = 1'b1;
    tick();
    armazena = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #2;
    chk("s6_conf", {31'b0, conflito}, 32'd0);
    chk("s6_pronto", {31'b0, pronto}, 32'd0);
    chk("s6_ocup", {31'b0, ocupado}, 32'd0);
    chk("s6_c0", {25'b0, celulas_j0}, 32'd0);
    chk("s6_c1", {25'b0, celulas_j1}, 32'd0);
    rd("s6_rd_j1", 1'b1, 0, 5, 1'b0);
    rd("s6_rd_j0", 1'b0, 2, 2, 1'b0);
    tick();
    reset = 1'b1;
    armazena = 1'b1;
    tick();
    armazena = 1'b0;
    chk("s6_idle", {31'b0, ocupado}, 32'd0);
    start("s6b", 1'b0, 0, 2, 2, 1'b0, 1'b0);
    espera("s6b", 5, 1'b0);

    // 7: commit interrupted by limpa
    armazena = 1'b1;
    tick();
    armazena = 1'b0;
    tick(); tick();
    limpa = 1'b1;
    tick();
    limpa = 1'b0;
    chk("s7_c0", {25'b0, celulas_j0}, 32'd0);
    chk("s7_ocup", {31'b0, ocupado}, 32'd0);
    rd("s7_rd", 1'b0, 2, 2, 1'b0);

    // 8: hidroaviao shape
    start("s8", 1'b0, 2, 0, 0, 1'b0, 1'b0);
    espera("s8", 3, 1'b0);
    armazena = 1'b1;
    tick();
    armazena = 1'b0;
    repeat (3) tick();
    chk("s8_c0", {25'b0, celulas_j0}, 32'd3);
    rd("s8_rd00", 1'b0, 0, 0, 1'b1);
    rd("s8_rd10", 1'b0, 1, 0, 1'b1);
`ifdef HIDROAVIAO_L_EN
    rd("s8_rd11", 1'b0, 1, 1, 1'b1);
    rd("s8_rd20", 1'b0, 2, 0, 1'b0);
    start("s8b", 1'b0, 2, 3, 7, 1'b0, 1'b0);
    espera("s8b", 3, 1'b1);
`else
    rd("s8_rd20", 1'b0, 2, 0, 1'b1);
    rd("s8_rd11", 1'b0, 1, 1, 1'b0);
    start("s8b", 1'b0, 2, 3, 7, 1'b0, 1'b0);
    espera("s8b", 3, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tabuleiro_pecas.md
# tabuleiro_pecas

Board store and conflict checker for the placement phase. It sits directly downstream of `PosicionandoPecas` and receives each candidate piece: player, type, origin, direction and orientation. It walks the piece's cells one per clock, checks that every cell is inside the 8×8 board and not already occupied, and returns `conflito`. On commit it writes the cells into that player's board. It also exposes a read port and per-player cell counters for the attack phase.

## Interface
Parameters:
- `TAM` = 8 — board side in cells; coordinates 0..TAM-1; fixed 3-bit coordinates, so only 8 is legal.

Ports:
- `clk`  in  1  — system clock; all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-low; clears both boards, counters and the FSM.
- `limpa`  in  1  — synchronous clear of both boards and counters; FSM forced to OCIOSO.
- `verifica`  in  1  — start a check; sampled in OCIOSO or AGUARDA.
- `armazena`  in  1  — commit the last checked piece; sampled in AGUARDA only.
- `jogador`  in  1  — board select, 0 or 1.
- `tipo`  in  3  — piece type: 0 porta-aviões (5 cells), 1 encouraçado (4), 2 hidroavião (3), 3 cruzador (2), 4 submarino (1); 5..7 are invalid.
- `X1`, `Y1`  in  3 each  — origin cell.
- `direcao`  in  1  — 0 = along X, 1 = along Y.
- `orientacao`  in  1  — 0 = increasing coordinate, 1 = decreasing.
- `rd_jogador`  in  1, `rd_x`  in  3, `rd_y`  in  3  — read-port address.
- `rd_ocupado`  out  1  — occupancy of the addressed cell; combinational.
- `conflito`  out  1  — result of the last check; valid while `pronto` = 1.
- `pronto`  out  1  — high in AGUARDA.
- `ocupado`  out  1  — high in VERIFICA and GRAVA.
- `celulas_j0`, `celulas_j1`  out  7 each  — occupied-cell count per player, 0..64.

## Operation
- Storage is 2×64 occupancy bits, indexed by `{jogador, Y, X}`.
- All piece inputs are latched when `verifica` is accepted. Later input changes have no effect until the next accepted `verifica`.
- Cell k (k = 0..len-1) is the origin offset by ±k along the axis chosen by `direcao`, with the sign set by `orientacao`.
  - Offset arithmetic is 4-bit signed.
  - A result below 0 or above 7 is out of bounds and counts as a conflict. There is no wrap-around.
- FSM states are OCIOSO, VERIFICA, AGUARDA, GRAVA.
- OCIOSO:
  - `verifica` = 1 → latch inputs, k = 0, go to VERIFICA.
  - `armazena` is ignored.
- VERIFICA: one cell is tested per cycle.
  - Cell k out of bounds or occupied → `conflito` = 1, go to AGUARDA (early exit).
  - k = len-1 with no fault → `conflito` = 0, go to AGUARDA.
  - Otherwise k increments.
  - Invalid `tipo` → `conflito` = 1, go to AGUARDA on the first VERIFICA cycle.
- AGUARDA:
  - `armazena` with `conflito` = 0 → k = 0, go to GRAVA.
  - `armazena` with `conflito` = 1 → go to OCIOSO, nothing written.
  - `verifica` alone → relatch inputs and restart the check.
  - `armazena` and `verifica` together → `armazena` wins.
- GRAVA:
  - Writes cell k each cycle and increments the latched player's counter.
  - After cell len-1 it returns to OCIOSO.
  - `verifica` and `armazena` are ignored.
- Priority: `reset` > `limpa` > FSM. `limpa` in any state, including mid-GRAVA, clears everything; a partial write is not preserved.

## Timing
- Reset values:
  - `conflito` = 0, `pronto` = 0, `ocupado` = 0.
  - `celulas_j0` = 0, `celulas_j1` = 0.
  - All board bits 0, so `rd_ocupado` = 0.
  - FSM in OCIOSO.
- Check latency:
  - `verifica` accepted at edge E0. Cell k is tested at edge E(k+1).
  - `pronto` and `conflito` are registered and valid after the edge that tests the last cell or the faulting cell.
  - Full 5-cell pass: `pronto` rises after E5. Fault at k = 2: `pronto` rises after E3. Invalid `tipo`: `pronto` rises after E1.
- Commit latency:
  - `armazena` accepted at G0: `pronto` drops after G0. Cell k is written at G(k+1). `ocupado` drops after G(len).
  - The counter increments at each write edge.
- Read port:
  - `rd_ocupado` is combinational from the board array.
  - A cell written at edge G reads 1 after G.

## Configuration
- `HIDROAVIAO_L_EN` defined: `tipo` 2 is an L shape.
  - Cells 0 and 1 follow the normal rule.
  - Cell 2 is cell 1 offset by +1 on the other axis, independent of `orientacao`, and is bounds-checked the same way.
- Undefined: `tipo` 2 is a straight 3-cell piece.
- The cell count is 3 in both builds.

## Test plan
- Reset, then `verifica` with j0, tipo 0, X1 = 2, Y1 = 2, direcao 0, orientacao 0 → `pronto` after 5 edges with `conflito` = 0. Then `armazena` → `celulas_j0` = 5 after 5 edges; `rd_ocupado` = 1 at (2..6, 2) and 0 at (7, 2).
- Then j0, tipo 1, X1 = 4, Y1 = 0, direcao 1, orientacao 0 → fault at k = 2, cell (4, 2); `pronto` after 3 edges with `conflito` = 1. Then `armazena` → OCIOSO, `celulas_j0` stays 5.
- j0, tipo 0, X1 = 5, Y1 = 0, direcao 0, orientacao 0 → k = 3 gives x = 8 (out of bounds) → `conflito` = 1 after 4 edges. Separately, X1 = 1, orientacao 1 → k = 2 gives x = -1 → `conflito` = 1 after 3 edges.
- j1 with the same piece as scenario 1 → `conflito` = 0; after commit `celulas_j1` = 5 and `celulas_j0` is unchanged.
- tipo 6 → `conflito` = 1 after 1 edge. Separately, `reset` asserted during the 3rd GRAVA cycle → all outputs 0, all board bits 0, FSM in OCIOSO.
- `HIDROAVIAO_L_EN` build: j0, tipo 2, X1 = 0, Y1 = 0, direcao 0, orientacao 0 → cells (0,0), (1,0), (1,1) are written. With Y1 = 7 → cell 2 at y = 8 → `conflito` = 1.
